quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
// PURPOSE
//  Receive side of the up/down counting path: decodes a 2-phase quadrature pair (A/B) from an
//  external encoder into direction, step pulses and a wrapping position count. Feeds the same
//  count/direction consumers that the up/down counter feeds. Inputs are asynchronous to clk.
// PARAMETERS
//  WIDTH        4  width of position count; wraps modulo 2**WIDTH
//  SYNC_STAGES  2  synchronizer flops per input (legal range 2..3)
// PORTS
//  clk    in   1      rising-edge clock, sole clock domain
//  rst    in   1      synchronous reset, active-low (0 = reset, sampled on clk rising edge)
//  a_in   in   1      encoder phase A, asynchronous
//  b_in   in   1      encoder phase B, asynchronous
//  clr    in   1      synchronous clear of count and err, active-high
//  count  out  WIDTH  position count
//  dir    out  1      direction of last valid step: 0 = up, 1 = down
//  step   out  1      1-cycle pulse per valid step
//  err    out  1      sticky illegal-transition flag
// BEHAVIOUR
//  - Reset (rst=0 at edge): sync flops=0, prev state=00, count=0, dir=0, step=0, err=0,
//    prime counter reloaded. All outputs are registered.
//  - Sync: a_in/b_in each pass through SYNC_STAGES flops -> s={a_s,b_s}; prev <= s every cycle.
//  - Prime: for the first SYNC_STAGES+1 edges after rst returns to 1, prev loads s with no
//    evaluation; no step, count, dir or err update. This prevents a false err when the
//    encoder rests at 11.
//  - Up sequence (AB): 00->01->11->10->00. Down is the reverse order.
//    Valid transition: step=1 for 1 cycle; count +/-1 mod 2**WIDTH; dir=0 (up) or 1 (down).
//  - s==prev: step=0; count and dir hold.
//  - Both bits changed (00<->11, 01<->10): step=0; count and dir hold; err<=1.
//    err stays set until clr or reset.
//  - Latency: an input change captured at edge N appears on count/step/dir at edge
//    N+SYNC_STAGES.
//  - Wrap: up from 2**WIDTH-1 -> 0; down from 0 -> 2**WIDTH-1. No saturation, no flag.
//  - clr=1: count<=0, err<=0, step<=0; dir holds. clr beats a simultaneous step or illegal
//    transition. prev keeps tracking s, so the next transition decodes correctly.
//  - Priority, high to low: rst, prime, clr, decode.
//  - Reset mid-operation: all state returns to reset values at that edge; prime restarts on
//    release.
// STRUCTURE
//  - Include file quad_defs.vh: localparams QD_S00=2'b00, QD_S01=2'b01, QD_S11=2'b11,
//    QD_S10=2'b10, DIR_UP=1'b0, DIR_DN=1'b1.
//  - Sub-module bit_sync: 1-bit SYNC_STAGES-deep synchronizer with synchronous active-low
//    rst; instantiate twice.
//  - Top level: prime counter, prev register, transition decode (case on {prev,s}),
//    count/dir/step/err registers.
// TESTING
//  1. rst=0 for 3 cycles with a_in=b_in=1, then release and hold -> count=0, dir=0, step=0,
//     err=0 throughout.
//  2. From 0, drive 16 up steps 4 cycles apart (00,01,11,10,...) -> count 1..15 then 0;
//     dir=0; exactly 16 step pulses, each 1 cycle wide; each update at edge N+2.
//  3. From count=0 at AB=00, drive AB=10 -> count=15 (wrap), dir=1, one step pulse.
//  4. At AB=00, count=5, drive AB=11 -> count=5, step=0, err=1. err still 1 after 10 more
//     valid steps. Pulse clr -> count=0, err=0.
//  5. Assert clr in the same cycle a valid up step decodes, from count=9 -> count=0, step=0.
//     The next up step gives count=1.
//  6. At count=7, rst=0 for 1 edge -> count=0, err=0, dir=0 next edge. No step for
//     SYNC_STAGES+1 edges after release, even with inputs toggling.

Source files
------------

// File: rtl/quadrature_decoder_pkg.sv
// Shared phase encodings, direction codes and the transition classifier
// used by the quadrature decoder.
package quadrature_decoder_pkg;

  localparam logic [1:0] QD_S00 = 2'b00;
  localparam logic [1:0] QD_S01 = 2'b01;
  localparam logic [1:0] QD_S11 = 2'b11;
  localparam logic [1:0] QD_S10 = 2'b10;
  localparam logic       DIR_UP = 1'b0;
  localparam logic       DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_UP   = 2'd1,
    TR_DN   = 2'd2,
    TR_ERR  = 2'd3
  } trans_t;

  // Gray-code walk: up is 00->01->11->10->00; a two-bit jump is illegal.
  function automatic trans_t decode_trans(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    t = TR_NONE;
    case ({prev, cur})
      {QD_S00, QD_S01}, {QD_S01, QD_S11},
      {QD_S11, QD_S10}, {QD_S10, QD_S00}: t = TR_UP;
      {QD_S01, QD_S00}, {QD_S11, QD_S01},
      {QD_S10, QD_S11}, {QD_S00, QD_S10}: t = TR_DN;
      {QD_S00, QD_S11}, {QD_S11, QD_S00},
      {QD_S01, QD_S10}, {QD_S10, QD_S01}: t = TR_ERR;
      default:                            t = TR_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/quadrature_decoder_bit_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous encoder phase.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronizes the phases, classifies each state
// change and maintains a wrapping position count, direction and error flag.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int            PW         = 3;
  localparam logic [PW-1:0] PRIME_LOAD = PW'(SYNC_STAGES + 1);

  logic          a_s;
  logic          b_s;
  logic [1:0]    s;
  logic [1:0]    prev;
  logic [PW-1:0] prime_cnt;
  trans_t        trans;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a_in),
    .q   (a_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (b_in),
    .q   (b_s)
  );

  assign s = {a_s, b_s};

  always_comb begin
    trans = decode_trans(prev, s);
  end

  // While priming, prev only follows s so a resting 11 never reads as 00->11.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= QD_S00;
      prime_cnt <= PRIME_LOAD;
      count     <= '0;
      dir       <= DIR_UP;
      step      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev <= s;
      step <= 1'b0;
      if (prime_cnt != '0) begin
        prime_cnt <= prime_cnt - PW'(1);
      end else if (clr) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        case (trans)
          TR_UP: begin
            count <= count + WIDTH'(1);
            dir   <= DIR_UP;
            step  <= 1'b1;
          end
          TR_DN: begin
            count <= count - WIDTH'(1);
            dir   <= DIR_DN;
            step  <= 1'b1;
          end
          TR_ERR:  err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed, table-driven bench for quadrature_decoder (WIDTH=4, SYNC_STAGES=2).
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in;
  logic       b_in;
  logic       clr;
  logic [3:0] count;
  logic       dir;
  logic       step;
  logic       err;

  always #5 clk = ~clk;

  quadrature_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .a_in  (a_in),
    .b_in  (b_in),
    .clr   (clr),
    .count (count),
    .dir   (dir),
    .step  (step),
    .err   (err)
  );

  typedef struct {
    logic [1:0] ab;
    logic       clr;
    logic [3:0] cnt;
    logic       dir;
    logic       err;
    int         steps;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   step_cnt  = 0;
  int   wide_cnt  = 0;
  logic prev_step = 1'b0;
  int   seg_a_end;
  logic [1:0] up_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  // Step pulse monitor: counts pulses and flags any pulse wider than a cycle.
  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (step === 1'b1 && prev_step === 1'b1) wide_cnt++;
    prev_step = step;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [1:0] ab, input logic c, input int cnt,
                              input logic d, input logic e, input int st);
    vec_t v;
    v.ab = ab; v.clr = c; v.cnt = cnt[3:0]; v.dir = d; v.err = e; v.steps = st;
    vecs.push_back(v);
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    vec_t v;
    int   s0;
    for (int i = lo; i <= hi; i++) begin
      v = vecs[i];
      a_in = v.ab[1];
      b_in = v.ab[0];
      clr  = v.clr;
      s0   = step_cnt;
      tick();
      clr = 1'b0;
      tick();
      tick();
      tick();
      chk($sformatf("vec%0d count", i), count, v.cnt);
      chk($sformatf("vec%0d dir", i), dir, v.dir);
      chk($sformatf("vec%0d err", i), err, v.err);
      chk($sformatf("vec%0d steps", i), step_cnt - s0, v.steps);
    end
  endtask

  initial begin
    // Segment A: starts at AB=11, count 0, just after the prime window.
    add(2'b10, 1'b0, 1, 1'b0, 1'b0, 1);
    add(2'b00, 1'b0, 2, 1'b0, 1'b0, 1);
    add(2'b00, 1'b1, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) add(up_seq[i % 4], 1'b0, (i + 1) % 16, 1'b0, 1'b0, 1);
    add(2'b10, 1'b0, 15, 1'b1, 1'b0, 1);
    add(2'b10, 1'b1, 0, 1'b1, 1'b0, 0);
    // From AB=10 the next up state is 00 (index 3 of up_seq).
    for (int i = 0; i < 5; i++) add(up_seq[(i + 3) % 4], 1'b0, i + 1, 1'b0, 1'b0, 1);
    add(2'b11, 1'b0, 5, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) add(up_seq[(i + 2) % 4], 1'b0, 6 + i, 1'b0, 1'b1, 1);
    add(2'b00, 1'b1, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 9; i++) add(up_seq[i % 4], 1'b0, i + 1, 1'b0, 1'b0, 1);
    seg_a_end = vecs.size();
    // Segment B: starts at AB=10, count 1.
    for (int i = 0; i < 7; i++) add(up_seq[(i + 3) % 4], 1'b0, i + 2, 1'b0, 1'b0, 1);
    add(2'b01, 1'b0, 7, 1'b1, 1'b0, 1);
    add(2'b10, 1'b0, 7, 1'b1, 1'b1, 0);

    // Reset held with the encoder resting at 11, then release and hold.
    rst = 1'b0; a_in = 1'b1; b_in = 1'b1; clr = 1'b0;
    repeat (3) tick();
    chk("rst count", count, 0);
    chk("rst dir", dir, 0);
    chk("rst step", step, 0);
    chk("rst err", err, 0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rest%0d count", i), count, 0);
      chk($sformatf("rest%0d dir", i), dir, 0);
      chk($sformatf("rest%0d step", i), step, 0);
      chk($sformatf("rest%0d err", i), err, 0);
    end

    run_vecs(0, seg_a_end - 1);

    // clr coincides with the decode edge of 01->11 from count 9.
    a_in = 1'b1; b_in = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    chk("clrstep count", count, 0);
    chk("clrstep step", step, 0);
    chk("clrstep err", err, 0);
    clr = 1'b0;
    tick();
    chk("clrstep after step", step, 0);
    chk("clrstep after count", count, 0);

    // Latency: change after edge 0 shows at edge 3 (capture edge 1 + 2).
    a_in = 1'b1; b_in = 1'b0;
    tick();
    chk("lat e1 count", count, 0);
    chk("lat e1 step", step, 0);
    tick();
    chk("lat e2 count", count, 0);
    chk("lat e2 step", step, 0);
    tick();
    chk("lat e3 count", count, 1);
    chk("lat e3 step", step, 1);
    chk("lat e3 dir", dir, 0);
    tick();
    chk("lat e4 step", step, 0);
    chk("lat e4 count", count, 1);

    run_vecs(seg_a_end, vecs.size() - 1);

    // Reset mid-operation (count 7, dir 1, err 1), inputs toggling during prime.
    rst = 1'b0;
    tick();
    chk("midrst count", count, 0);
    chk("midrst dir", dir, 0);
    chk("midrst err", err, 0);
    chk("midrst step", step, 0);
    rst = 1'b1; a_in = 1'b0; b_in = 1'b1;
    tick();
    chk("prime1 step", step, 0);
    chk("prime1 count", count, 0);
    a_in = 1'b1; b_in = 1'b1;
    tick();
    chk("prime2 step", step, 0);
    chk("prime2 count", count, 0);
    tick();
    chk("prime3 step", step, 0);
    chk("prime3 count", count, 0);
    tick();
    chk("postprime count", count, 1);
    chk("postprime step", step, 1);
    chk("postprime dir", dir, 0);
    tick();
    chk("postprime2 step", step, 0);
    chk("postprime2 count", count, 1);
    chk("postprime2 err", err, 0);

    chk("step width", wide_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
